// File: rtl/temp_pkg.sv
// temp_pkg: shared sample type, fixed-point format constants and averager FSM states
package temp_pkg;
    localparam int TEMP_W    = 13;
    localparam int TEMP_FRAC = 4;
    typedef logic signed [TEMP_W-1:0] temp_t;
    typedef enum logic {FILL, RUN} avg_state_t;
endpackage

// File: rtl/avg_ring.sv
// avg_ring: sample ring buffer with write pointer; presents the sample about to be overwritten
module avg_ring
    import temp_pkg::*;
#(
    parameter int W      = TEMP_W,
    parameter int LOG2_N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr,
    input  logic signed [W-1:0] din,
    output logic signed [W-1:0] evict
);
    localparam int N = 1 << LOG2_N;

    logic signed [W-1:0] mem [N];
    logic [LOG2_N-1:0]   wr_ptr;

    assign evict = mem[wr_ptr];

    // store each accepted sample over the oldest one; pointer wraps naturally at 2^LOG2_N
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (wr) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + LOG2_N'(1);
        end
    end
endmodule

// File: rtl/temp_avg.sv
// temp_avg: moving-average filter over the last 2^LOG2_N temperature samples with rounded output.
// Optional TEMP_AVG_MINMAX_EN adds min_o/max_o tracking of the valid averages.
module temp_avg
    import temp_pkg::*;
#(
    parameter int W      = TEMP_W,
    parameter int LOG2_N = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy_i,
    input  logic signed [W-1:0] temp_i,
    input  logic                clr_i,
    output logic signed [W-1:0] avg_o,
    output logic                avg_valid_o,
    output logic                avg_upd_o,
`ifdef TEMP_AVG_MINMAX_EN
    output logic signed [W-1:0] min_o,
    output logic signed [W-1:0] max_o,
`endif
    output logic [LOG2_N:0]     fill_o
);
    localparam int SW = W + LOG2_N;
    localparam logic [LOG2_N:0] FULL = (LOG2_N+1)'(1 << LOG2_N);

    logic                 rdy_q, accept, pend;
    avg_state_t           state, state_nxt;
    logic signed [SW-1:0] sum, sum_nxt;
    logic signed [W-1:0]  avg_nxt;
    logic [LOG2_N:0]      fill_nxt;

    assign accept = rdy_i & ~rdy_q;

    if (LOG2_N == 0) begin : g_bypass
        assign sum_nxt = temp_i;
        assign avg_nxt = sum;
    end else begin : g_ring
        localparam logic signed [SW:0] HALF = (SW+1)'(1) <<< (LOG2_N-1);
        logic signed [W-1:0] evict;
        logic signed [SW:0]  rnd;
        avg_ring #(.W(W), .LOG2_N(LOG2_N)) u_ring (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr_i),
            .wr   (accept & ~clr_i),
            .din  (temp_i),
            .evict(evict)
        );
        assign sum_nxt = sum + SW'(temp_i) - SW'(evict);
        assign rnd     = (SW+1)'(sum) + HALF;
        assign avg_nxt = W'(rnd >>> LOG2_N);
    end

    // saturating fill count and the FILL->RUN decision on the accept that completes the window
    always_comb begin
        fill_nxt  = (fill_o == FULL) ? fill_o : fill_o + (LOG2_N+1)'(1);
        state_nxt = (accept && fill_nxt == FULL) ? RUN : state;
    end

    // accept updates sum/fill; the following edge publishes the rounded average
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            pend        <= 1'b0;
            state       <= FILL;
            sum         <= '0;
            fill_o      <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
            avg_upd_o   <= 1'b0;
        end else if (clr_i) begin
            rdy_q       <= 1'b0;
            pend        <= 1'b0;
            state       <= FILL;
            sum         <= '0;
            fill_o      <= '0;
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
            avg_upd_o   <= 1'b0;
        end else begin
            rdy_q       <= rdy_i;
            pend        <= accept;
            state       <= state_nxt;
            avg_upd_o   <= pend;
            avg_valid_o <= (state == RUN);
            if (accept) begin
                sum    <= sum_nxt;
                fill_o <= fill_nxt;
            end
            if (pend) avg_o <= avg_nxt;
        end
    end

`ifdef TEMP_AVG_MINMAX_EN
    localparam logic signed [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] NEG_MAX = -POS_MAX;

    // extremes of the full-window averages, compared against the value being published
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_o <= POS_MAX;
            max_o <= NEG_MAX;
        end else if (clr_i) begin
            min_o <= POS_MAX;
            max_o <= NEG_MAX;
        end else if (pend && state == RUN) begin
            if (avg_nxt < min_o) min_o <= avg_nxt;
            if (avg_nxt > max_o) max_o <= avg_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_temp_avg.sv
// tb_temp_avg: directed self-checking bench for temp_avg (default build, LOG2_N=3)
module tb_temp_avg;
    localparam int W = 13;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                rdy_i = 1'b0;
    logic signed [W-1:0] temp_i = '0;
    logic                clr_i = 1'b0;
    logic signed [W-1:0] avg_o;
    logic                avg_valid_o, avg_upd_o;
    logic [3:0]          fill_o;
`ifdef TEMP_AVG_MINMAX_EN
    logic signed [W-1:0] min_o, max_o;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int upd_cnt = 0;

    temp_avg #(.W(W), .LOG2_N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy_i      (rdy_i),
        .temp_i     (temp_i),
        .clr_i      (clr_i),
        .avg_o      (avg_o),
        .avg_valid_o(avg_valid_o),
        .avg_upd_o  (avg_upd_o),
`ifdef TEMP_AVG_MINMAX_EN
        .min_o      (min_o),
        .max_o      (max_o),
`endif
        .fill_o     (fill_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (avg_upd_o === 1'b1) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0d exp %0d", tag, got, exp);
    endtask

    // rising edge on rdy_i with sample t; returns at the negedge where the new average is visible
    task automatic push(input int t);
        @(negedge clk);
        temp_i = W'(t);
        rdy_i  = 1'b1;
        @(negedge clk);
        rdy_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_400(input string pfx);
        for (int i = 0; i < 8; i++) begin
            push(400);
            chk({pfx, "_fill"}, fill_o, i + 1);
            chk({pfx, "_valid"}, avg_valid_o, i == 7);
            chk({pfx, "_upd"}, avg_upd_o, 1);
            chk({pfx, "_avg"}, avg_o, 50 * (i + 1));
        end
    endtask

    initial begin
        #2;
        chk("rst_avg", avg_o, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_valid", avg_valid_o, 0);
        chk("rst_upd", avg_upd_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_400("fill");

        for (int k = 1; k <= 8; k++) begin
            push(800);
            chk("step_avg", avg_o, 400 + 50 * k);
        end
        chk("step_valid", avg_valid_o, 1);

        for (int k = 0; k < 8; k++) push(-160);
        chk("neg160", avg_o, -160);
        chk("neg160_hex", avg_o & 32'h1FFF, 32'h1F60);

        for (int k = 0; k < 4; k++) push(-1);
        for (int k = 0; k < 4; k++) push(0);
        chk("rnd_m4", avg_o, 0);

        for (int k = 0; k < 4; k++) push(-1);
        for (int k = 0; k < 4; k++) push(-2);
        chk("rnd_m12", avg_o, -1);

        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr_fill", fill_o, 0);
        chk("clr_valid", avg_valid_o, 0);
        chk("clr_avg", avg_o, 0);

        upd_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            temp_i = W'(16 * (i + 1));
            rdy_i  = 1'b1;
        end
        @(negedge clk);
        rdy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_upd_cnt", upd_cnt, 1);
        chk("hold_fill", fill_o, 1);
        chk("hold_avg", avg_o, 2);

        for (int k = 0; k < 4; k++) push(400);
        chk("pre_clr_fill", fill_o, 5);
        @(negedge clk);
        temp_i = W'(400);
        rdy_i  = 1'b1;
        clr_i  = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        rdy_i = 1'b0;
        chk("clracc_fill", fill_o, 0);
        chk("clracc_avg", avg_o, 0);
        chk("clracc_valid", avg_valid_o, 0);
        repeat (3) @(negedge clk);
        chk("clracc_drop", fill_o, 0);
        chk("clracc_noupd", avg_o, 0);
        push(400);
        chk("after_clr_avg", avg_o, 50);
        chk("after_clr_fill", fill_o, 1);

        for (int k = 0; k < 7; k++) push(400);
        chk("run_valid", avg_valid_o, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_avg", avg_o, 0);
        chk("arst_fill", fill_o, 0);
        chk("arst_valid", avg_valid_o, 0);
        chk("arst_upd", avg_upd_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_400("refill");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/temp_avg.md
Name: temp_avg

Overview:
- Moving-average filter between the TempSensorCtl output (13-bit two's-complement temperature, 4 fractional bits) and the unit-conversion/display path.
- Accepts one sample per rising edge of the sensor ready signal and keeps the last 2^LOG2_N samples in a ring buffer with a running sum.
- Outputs a rounded average in the same fixed-point format, which makes the display stable against sensor LSB jitter.

Parameters:
- W, 13, sample width (signed, 4 fractional bits)
- LOG2_N, 3, log2 of the window length; legal range 0..5; 0 means bypass (average = last sample)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rdy_i  input  1  sensor ready level; a sample is accepted on its 0->1 transition
- temp_i  input  W  signed sample; valid in the cycle in which rdy_i rises
- clr_i  input  1  synchronous clear; same effect as reset
- avg_o  output  W  signed rounded average
- avg_valid_o  output  1  high once the window is full
- avg_upd_o  output  1  one-cycle pulse when avg_o changes due to a new sample
- fill_o  output  LOG2_N+1  number of samples held, saturating at 2^LOG2_N

Behaviour:
- Reset (rst_n=0, async) clears the following to 0: rdy_q, all buffer entries, sum, wr_ptr, fill, avg_o, avg_valid_o, avg_upd_o. The FSM returns to FILL.
- Edge detect: rdy_q registers rdy_i. accept = rdy_i & ~rdy_q.
  - rdy_i held high for many cycles produces exactly one accept.
  - rdy_i high when coming out of reset counts as a rising edge.
- Accept, at edge k:
  - sum <= sum + temp_i - buf[wr_ptr] (sign-extended; sum is W+LOG2_N bits signed, so it cannot overflow)
  - buf[wr_ptr] <= temp_i
  - wr_ptr <= wr_ptr+1, wrapping from 2^LOG2_N-1 to 0
  - fill increments, saturating at 2^LOG2_N
- Output, at edge k+1:
  - avg_o <= (sum + 2^(LOG2_N-1)) >>> LOG2_N, truncated to W bits. This is round-half-toward-+inf; the result always fits W bits.
  - avg_upd_o pulses high for exactly that one cycle.
  - Latency from accept to avg_o = 1 cycle after the sum update, i.e. 2 clk edges from the rdy_i rise being sampled.
- FSM:
  - FILL: avg_valid_o=0, avg_o still updates with the partial sum (zeros in the empty slots). Go to RUN on the accept that makes fill = 2^LOG2_N.
  - RUN: avg_valid_o=1 from the same edge at which avg_o first shows the full-window average. Stay in RUN until reset or clr.
- clr_i=1 has the same effect as reset, applied at the next edge. If clr_i and accept occur in the same cycle, clr_i wins and the sample is dropped.
- LOG2_N=0: no buffer; avg_o <= temp_i one cycle after accept; avg_valid_o high after the first accept.
- No back-pressure. Samples arrive at most once per ~240 ms, so no input queueing is needed.

Optional Feature:
TEMP_AVG_MINMAX_EN
- Defined: adds ports min_o and max_o (each W bits, signed). They track the extreme avg_o values while avg_valid_o=1.
  - Reset/clr sets min_o to +max and max_o to -max.
  - Both are updated in the same cycle as avg_o, using compare against the new average.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package temp_pkg holds:
  - TEMP_W = 13 and typedef temp_t (logic signed [TEMP_W-1:0])
  - enum avg_state_t {FILL, RUN}
  - TEMP_FRAC = 4
- One natural sub-module, avg_ring: holds the ring buffer plus write pointer, and returns the evicted sample (buf[wr_ptr]) combinationally.

Test Plan:
- Reset, then 8 rising edges of rdy_i with temp_i=400 (25.0 C):
  - fill_o steps 1..8 and avg_valid_o stays 0 until the 8th sample.
  - avg_o after the 8th sample = 400, avg_valid_o=1, one avg_upd_o pulse per sample.
- Step response: window full of 400, then samples of 800. avg_o = 450, 500, 550, 600, ..., 800 after the 8th new sample.
- Negatives and rounding:
  - Window of -160 (0x1F60): avg_o = 0x1F60.
  - 4×(-1) plus 4×0: sum -4, avg_o = 0.
  - 4×(-1) plus 4×(-2): sum -12, avg_o = -1.
- Hold rdy_i high for 100 cycles with temp_i changing every cycle: exactly one accept. fill_o rises by 1 and avg_upd_o pulses once.
- clr_i:
  - clr_i asserted in the same cycle as a rising edge at fill=5: fill_o=0, avg_o=0, avg_valid_o=0, sample dropped.
  - Next accept of 400: avg_o = 50.
- Async reset: rst_n pulsed low mid-cycle during RUN. All outputs are 0 immediately, without a clk edge. Refill with 8 samples: behaviour matches the first test.
